// File: rtl/calculator_pkg.sv
// calculator_pkg: shared types and defaults for the banked-SRAM calculator
package calculator_pkg;

    localparam int ADDR_W              = 9;
    localparam int CALC_DATA_W_DEFAULT = 32;
    localparam int CALC_LANES_DEFAULT  = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ_A = 3'd1,
        S_READ_B = 3'd2,
        S_CALC   = 3'd3,
        S_WRITE  = 3'd4,
        S_END    = 3'd5
    } calc_state_t;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'd0,
        MODE_SUB  = 2'd1,
        MODE_ACC  = 2'd2,
        MODE_RSVD = 2'd3
    } calc_mode_t;

endpackage

// File: rtl/calc_lane_adder.sv
// calc_lane_adder: ripple of LANES DATA_W-bit adders computing a+b, a-b or acc+a+b
module calc_lane_adder #(
    parameter int DATA_W = calculator_pkg::CALC_DATA_W_DEFAULT,
    parameter int LANES  = calculator_pkg::CALC_LANES_DEFAULT
) (
    input  logic                    sub,
    input  logic                    acc_sel,
    input  logic [LANES*DATA_W-1:0] a,
    input  logic [LANES*DATA_W-1:0] b,
    input  logic [LANES*DATA_W-1:0] acc,
    output logic [LANES*DATA_W-1:0] sum,
    output logic                    carry
);

    // Three-operand adds can carry 2 between lanes, so the lane carry is 2 bits wide
    logic [1:0]        c;
    logic [DATA_W+1:0] t;

    // Carry/borrow ripples lane 0 upward; carry reports a borrow when subtracting
    always_comb begin
        c   = {1'b0, sub};
        t   = '0;
        sum = '0;
        for (int k = 0; k < LANES; k++) begin
            t = {2'b00, a[k*DATA_W +: DATA_W]}
              + {2'b00, sub ? ~b[k*DATA_W +: DATA_W] : b[k*DATA_W +: DATA_W]}
              + (acc_sel ? {2'b00, acc[k*DATA_W +: DATA_W]} : '0)
              + {{DATA_W{1'b0}}, c};
            sum[k*DATA_W +: DATA_W] = t[DATA_W-1:0];
            c = t[DATA_W+1:DATA_W];
        end
        carry = sub ? ~c[0] : |c;
    end

endmodule

// File: rtl/calc_seq.sv
// calc_seq: walks a read range in operand pairs through banked SRAM and writes results
module calc_seq #(
    parameter int ADDR_W = calculator_pkg::ADDR_W,
    parameter int DATA_W = calculator_pkg::CALC_DATA_W_DEFAULT,
    parameter int LANES  = calculator_pkg::CALC_LANES_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  calculator_pkg::calc_mode_t mode,
    input  logic [ADDR_W-1:0]          read_start_addr,
    input  logic [ADDR_W-1:0]          read_end_addr,
    input  logic [ADDR_W-1:0]          write_start_addr,
    input  logic [ADDR_W-1:0]          write_end_addr,
    output logic                       mem_re,
    output logic [ADDR_W-1:0]          mem_raddr,
    input  logic [LANES*DATA_W-1:0]    mem_rdata,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_waddr,
    output logic [LANES*DATA_W-1:0]    mem_wdata,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow,
    output logic                       truncated,
    output logic [31:0]                cycle_count
);

    import calculator_pkg::*;

    localparam int W = LANES * DATA_W;

    calc_state_t       state_q, state_d;
    calc_mode_t        mode_q, mode_d;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [ADDR_W-1:0] rd_end_q, rd_end_d;
    logic [ADDR_W-1:0] wr_end_q, wr_end_d;
    logic [ADDR_W-1:0] mem_raddr_q, mem_raddr_d;
    logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      acc_q, acc_d;
    logic [W-1:0]      mem_wdata_q, mem_wdata_d;
    logic              rd_done_q, rd_done_d;
    logic              odd_q, odd_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              trunc_q, trunc_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [W-1:0]      op_a, op_b, sum;
    logic              carry;

    // A trailing odd operand arrives in S_CALC itself and pairs with zero
    assign op_a = odd_q ? mem_rdata : a_q;
    assign op_b = odd_q ? '0 : mem_rdata;

    calc_lane_adder #(
        .DATA_W (DATA_W),
        .LANES  (LANES)
    ) u_adder (
        .sub     (mode_q == MODE_SUB),
        .acc_sel (mode_q == MODE_ACC),
        .a       (op_a),
        .b       (op_b),
        .acc     (acc_q),
        .sum     (sum),
        .carry   (carry)
    );

    // Next-state logic; outputs are derived from the next state so they register with it
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        r_addr_d  = r_addr_q;
        w_addr_d  = w_addr_q;
        rd_end_d  = rd_end_q;
        wr_end_d  = wr_end_q;
        a_d       = a_q;
        acc_d     = acc_q;
        rd_done_d = rd_done_q;
        odd_d     = odd_q;
        ovf_d     = ovf_q;
        trunc_d   = trunc_q;
        cnt_d     = busy_q ? cnt_q + 32'd1 : cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d   = mode;
                    r_addr_d = read_start_addr;
                    w_addr_d = write_start_addr;
                    rd_end_d = read_end_addr;
                    wr_end_d = write_end_addr;
                    if (read_end_addr < read_start_addr || write_end_addr < write_start_addr) begin
                        state_d = S_END;
                    end else begin
                        ovf_d     = 1'b0;
                        trunc_d   = 1'b0;
                        cnt_d     = '0;
                        acc_d     = '0;
                        rd_done_d = 1'b0;
                        odd_d     = 1'b0;
                        state_d   = S_READ_A;
                    end
                end
            end
            S_READ_A: begin
                odd_d     = (r_addr_q == rd_end_q);
                rd_done_d = odd_d;
                r_addr_d  = odd_d ? r_addr_q : r_addr_q + 1'b1;
                state_d   = odd_d ? S_CALC : S_READ_B;
            end
            S_READ_B: begin
                a_d       = mem_rdata;
                rd_done_d = (r_addr_q == rd_end_q);
                r_addr_d  = rd_done_d ? r_addr_q : r_addr_q + 1'b1;
                state_d   = S_CALC;
            end
            S_CALC: begin
                ovf_d   = ovf_q | carry;
                acc_d   = (mode_q == MODE_ACC) ? sum : acc_q;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (rd_done_q) begin
                    state_d = S_END;
                end else if (w_addr_q == wr_end_q) begin
                    trunc_d = 1'b1;
                    state_d = S_END;
                end else begin
                    w_addr_d = w_addr_q + 1'b1;
                    state_d  = S_READ_A;
                end
            end
            S_END: state_d = start ? S_END : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        mem_re_d    = (state_d == S_READ_A) || (state_d == S_READ_B);
        mem_raddr_d = mem_re_d ? r_addr_d : mem_raddr_q;
        mem_we_d    = (state_d == S_WRITE);
        mem_waddr_d = mem_we_d ? w_addr_d : mem_waddr_q;
        mem_wdata_d = mem_we_d ? sum : mem_wdata_q;
        busy_d      = !(state_d == S_IDLE || state_d == S_END);
        done_d      = (state_d == S_END);
    end

    // State and registered outputs; reset clears everything on the same edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            mode_q      <= MODE_ADD;
            r_addr_q    <= '0;
            w_addr_q    <= '0;
            rd_end_q    <= '0;
            wr_end_q    <= '0;
            a_q         <= '0;
            acc_q       <= '0;
            rd_done_q   <= 1'b0;
            odd_q       <= 1'b0;
            ovf_q       <= 1'b0;
            trunc_q     <= 1'b0;
            cnt_q       <= '0;
            mem_re_q    <= 1'b0;
            mem_raddr_q <= '0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            r_addr_q    <= r_addr_d;
            w_addr_q    <= w_addr_d;
            rd_end_q    <= rd_end_d;
            wr_end_q    <= wr_end_d;
            a_q         <= a_d;
            acc_q       <= acc_d;
            rd_done_q   <= rd_done_d;
            odd_q       <= odd_d;
            ovf_q       <= ovf_d;
            trunc_q     <= trunc_d;
            cnt_q       <= cnt_d;
            mem_re_q    <= mem_re_d;
            mem_raddr_q <= mem_raddr_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Gating with rst keeps a write from landing on the edge where reset hits S_WRITE
    assign mem_we      = mem_we_q & rst;
    assign mem_re      = mem_re_q;
    assign mem_raddr   = mem_raddr_q;
    assign mem_waddr   = mem_waddr_q;
    assign mem_wdata   = mem_wdata_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign overflow    = ovf_q;
    assign truncated   = trunc_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_calc_seq.sv
// tb_calc_seq: scoreboard bench for calc_seq with a 1-cycle-latency SRAM model
module tb_calc_seq;

    import calculator_pkg::*;

    localparam int W     = 64;
    localparam int DEPTH = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [W-1:0]      data;
    } wr_t;

    typedef struct {
        string    name;
        logic [W-1:0] act;
        logic [W-1:0] exp;
    } chk_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    calc_mode_t        mode = MODE_ADD;
    logic [ADDR_W-1:0] read_start_addr = '0, read_end_addr = '0;
    logic [ADDR_W-1:0] write_start_addr = '0, write_end_addr = '0;
    logic              mem_re, mem_we, busy, done, overflow, truncated;
    logic [ADDR_W-1:0] mem_raddr, mem_waddr;
    logic [W-1:0]      mem_rdata, mem_wdata;
    logic [31:0]       cycle_count;

    logic [W-1:0] mem  [0:DEPTH-1];
    logic [W-1:0] wmem [0:DEPTH-1];
    wr_t  exp_q[$];
    chk_t chk_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   wr_cnt = 0;
    int   base;

    calc_seq dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .mode             (mode),
        .read_start_addr  (read_start_addr),
        .read_end_addr    (read_end_addr),
        .write_start_addr (write_start_addr),
        .write_end_addr   (write_end_addr),
        .mem_re           (mem_re),
        .mem_raddr        (mem_raddr),
        .mem_rdata        (mem_rdata),
        .mem_we           (mem_we),
        .mem_waddr        (mem_waddr),
        .mem_wdata        (mem_wdata),
        .busy             (busy),
        .done             (done),
        .overflow         (overflow),
        .truncated        (truncated),
        .cycle_count      (cycle_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) wmem[mem_waddr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_raddr];
    end

    always @(negedge clk) begin
        while (chk_q.size() > 0) begin
            chk_t c;
            c = chk_q.pop_front();
            n_checks++;
            if (c.act !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got %h, expected %h", c.name, c.act, c.exp);
            end
        end
        if (mem_we === 1'b1) begin
            wr_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL write: unexpected write addr %h data %h", mem_waddr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (mem_waddr !== e.addr || mem_wdata !== e.data) begin
                    n_fail++;
                    $display("FAIL write: got addr %h data %h, expected addr %h data %h",
                             mem_waddr, mem_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic expect_wr(input int a, input logic [W-1:0] d);
        exp_q.push_back('{addr: ADDR_W'(a), data: d});
    endtask

    task automatic setup(input calc_mode_t m, input int rs, input int re, input int ws, input int we);
        mode             = m;
        read_start_addr  = ADDR_W'(rs);
        read_end_addr    = ADDR_W'(re);
        write_start_addr = ADDR_W'(ws);
        write_end_addr   = ADDR_W'(we);
        base             = wr_cnt;
    endtask

    task automatic go();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run(input string tag, input calc_mode_t m, input int rs, input int re,
                       input int ws, input int we, input int cyc, input bit ovf,
                       input bit tr, input int nwr);
        setup(m, rs, re, ws, we);
        go();
        for (int i = 0; i < 2000; i++) begin
            if (done === 1'b1) break;
            @(posedge clk); #1;
        end
        check({tag, " done"}, done, 1);
        check({tag, " busy"}, busy, 0);
        check({tag, " cycle_count"}, cycle_count, cyc);
        check({tag, " overflow"}, overflow, ovf);
        check({tag, " truncated"}, truncated, tr);
        check({tag, " writes"}, wr_cnt - base, nwr);
        check({tag, " pending"}, exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " mem_re"}, mem_re, 0);
        check({tag, " mem_we"}, mem_we, 0);
        check({tag, " overflow"}, overflow, 0);
        check({tag, " truncated"}, truncated, 0);
        check({tag, " cycle_count"}, cycle_count, 0);
        check({tag, " mem_raddr"}, mem_raddr, 0);
        check({tag, " mem_waddr"}, mem_waddr, 0);
        check({tag, " mem_wdata"}, mem_wdata, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b1;

        for (int i = 0; i < 256; i++) mem[i] = W'(i);
        for (int k = 0; k < 128; k++) expect_wr(384 + k, W'(4 * k + 1));
        run("add_full", MODE_ADD, 0, 255, 384, 511, 512, 0, 0, 128);

        mem[0] = 64'h0000_0000_FFFF_FFFF;
        mem[1] = 64'h0000_0000_0000_0001;
        expect_wr(10, 64'h0000_0001_0000_0000);
        run("lane_carry", MODE_ADD, 0, 1, 10, 10, 4, 0, 0, 1);

        mem[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        mem[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        expect_wr(11, 64'hFFFF_FFFF_FFFF_FFFE);
        run("word_carry", MODE_ADD, 0, 1, 11, 11, 4, 1, 0, 1);

        mem[0] = 64'd5;
        mem[1] = 64'd7;
        expect_wr(20, 64'hFFFF_FFFF_FFFF_FFFE);
        run("sub", MODE_SUB, 0, 1, 20, 20, 4, 1, 0, 1);

        expect_wr(50, 64'd12);
        run("reserved", MODE_RSVD, 0, 1, 50, 50, 4, 0, 0, 1);

        for (int i = 0; i < 6; i++) mem[i] = W'(i + 1);
        expect_wr(30, 64'd3);
        expect_wr(31, 64'd10);
        expect_wr(32, 64'd21);
        run("acc_even", MODE_ACC, 0, 5, 30, 40, 12, 0, 0, 3);

        expect_wr(33, 64'd3);
        expect_wr(34, 64'd10);
        expect_wr(35, 64'd15);
        run("acc_odd", MODE_ACC, 0, 4, 33, 40, 11, 0, 0, 3);

        for (int i = 0; i < 16; i++) mem[i] = W'(i);
        expect_wr(100, 64'd1);
        expect_wr(101, 64'd5);
        run("trunc", MODE_ADD, 0, 15, 100, 101, 8, 0, 1, 2);

        setup(MODE_ADD, 10, 3, 60, 70);
        go();
        check("reversed done", done, 1);
        check("reversed busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        check("reversed writes", wr_cnt - base, 0);

        setup(MODE_ADD, 0, 15, 200, 215);
        expect_wr(200, 64'd1);
        expect_wr(201, 64'd5);
        go();
        repeat (11) @(posedge clk);
        #1;
        check("mid_rst we_before", mem_we, 1);
        rst = 1'b0;
        #1;
        check("mid_rst we_gated", mem_we, 0);
        @(posedge clk); #1;
        check_zero("mid_rst");
        check("mid_rst writes", wr_cnt - base, 2);
        check("mid_rst pending", exp_q.size(), 0);
        rst = 1'b1;

        expect_wr(200, 64'd1);
        expect_wr(201, 64'd5);
        run("restart", MODE_ADD, 0, 3, 200, 210, 8, 0, 0, 2);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_seq.md
# calc_seq

Parametrised successor to the fixed two-bank 32-bit calculator controller. It walks a read address range in operand pairs through external SRAM banks and applies a selectable operation (ADD, SUB, ACC) across `LANES` chained `DATA_W` banks. Results are written to a write address range, and the block reports busy/done, sticky overflow, truncation and a cycle count. It sits in `top_lvl` in place of the current controller and drives the banked SRAM ports directly.

## Interface
- `ADDR_W`, 9, SRAM address width
- `DATA_W`, 32, width of one SRAM bank (lane)
- `LANES`, 2, number of banks forming one word; word width `W = LANES*DATA_W`
- `clk`  in  1  single clock; all logic on posedge
- `rst`  in  1  reset, synchronous, active-low
- `start`  in  1  level; sampled only in S_IDLE
- `mode`  in  2  `calc_mode_t`: 0 ADD, 1 SUB, 2 ACC, 3 reserved (treated as ADD)
- `read_start_addr`, `read_end_addr`  in  ADDR_W  inclusive operand range
- `write_start_addr`, `write_end_addr`  in  ADDR_W  inclusive result range
- `mem_re`  out  1  read enable, all lanes
- `mem_raddr`  out  ADDR_W  read address
- `mem_rdata`  in  W  lane k on bits `[k*DATA_W +: DATA_W]`; valid 1 cycle after `mem_re`
- `mem_we`  out  1  write enable, all lanes
- `mem_waddr`  out  ADDR_W  write address
- `mem_wdata`  out  W  result word
- `busy`  out  1  high in any state other than S_IDLE and S_END
- `done`  out  1  high while in S_END
- `overflow`  out  1  sticky; carry out of the word MSB (ADD/ACC) or borrow (SUB)
- `truncated`  out  1  sticky; write range exhausted while operands remained
- `cycle_count`  out  32  cycles spent busy in the last or current run

## Operation
- States (`calc_state_t`): S_IDLE, S_READ_A, S_READ_B, S_CALC, S_WRITE, S_END.
- S_IDLE: `start=1` latches all address inputs and `mode`.
  - If `read_end_addr < read_start_addr` or `write_end_addr < write_start_addr`, go to S_END with zero writes.
  - Otherwise clear `overflow`, `truncated`, `cycle_count` and the accumulator, then go to S_READ_A.
- S_READ_A: `mem_re=1`, `mem_raddr=r_addr`; r_addr++.
  - If r_addr was `read_end`, go to S_CALC with B forced to 0 (odd operand count).
  - Else go to S_READ_B.
- S_READ_B: capture A from `mem_rdata`; issue read of B; r_addr++; go to S_CALC.
- S_CALC: capture B (or use the pending A with B=0). Compute the result:
  - ADD: A+B.
  - SUB: A−B (two's complement).
  - ACC: acc+A+B; acc ← result.
  - Carry/borrow propagates lane 0 → lane LANES−1. The final carry ORs into `overflow`.
- S_WRITE: `mem_we=1`, `mem_waddr=w_addr`, `mem_wdata=result`; w_addr++. Next state:
  - Reads exhausted: S_END.
  - Else w_addr was `write_end`: set `truncated`, go to S_END.
  - Else: S_READ_A.
- S_END: hold all outputs; return to S_IDLE when `start=0`.
- `start` is ignored outside S_IDLE and S_END.
- Addresses never wrap. Exhaustion is compared against the latched end address before increment, so `end = 2^ADDR_W−1` is safe.

## Timing
- Reset (`rst=0` at posedge):
  - State goes to S_IDLE.
  - All outputs go to 0: `mem_re`, `mem_we`, `busy`, `done`, `overflow`, `truncated`, `cycle_count`, addresses, `mem_wdata`.
- Reset mid-operation takes effect on the same edge. No write is issued in that cycle.
- SRAM read latency is fixed at 1 cycle.
- Cycles per result: 4 for a full pair, 3 for the trailing odd operand.
- The `mem_we` pulse lasts exactly 1 cycle per result.
- `cycle_count` increments on each cycle with `busy=1` and holds in S_END/S_IDLE. A full N-pair run gives `cycle_count = 4N`.
- `done` rises on the cycle after the last `mem_we`.

## Structure
- `calculator_pkg` gains:
  - `calc_state_t`
  - `calc_mode_t`
  - `CALC_LANES_DEFAULT`
  - The existing `ADDR_W`, which becomes the default source.
- Sub-module `calc_lane_adder`:
  - Combinational ripple of LANES `DATA_W` adders.
  - Inputs: `sub`, A, B, acc-select.
  - Outputs: sum and carry.
- The controller FSM, counters and registers live in `calc_seq`.

## Test plan
- ADD, LANES=2, read 0..255, write 384..511, operands `i` at address `i` → `mem[384+k] = (2k)+(2k+1)`; 128 writes; `cycle_count=512`; `done=1`; `overflow=0`.
- Lane carry: A=`0x00000000_FFFFFFFF`, B=1 → result `0x00000001_00000000`; `overflow=0`. A=B=`0xFFFF…F` → `overflow=1`.
- SUB: A=5, B=7 → result `0xFFFF_FFFF_FFFF_FFFE`; `overflow=1`.
- ACC, reads 0..5 holding 1..6 → writes 3, 10, 21; odd range 0..4 → last write `acc+5+0`; `cycle_count=11`.
- Truncation: read 0..15 with write 100..101 → exactly 2 writes; `truncated=1`. Reversed read range 10..3 → S_END next cycle with no `mem_we`.
- Assert `rst=0` during S_WRITE of write 3 → no write at that edge; all outputs 0. A new `start` runs cleanly from write_start.
